// File: rtl/memoria_cargador_if.sv
// Byte-stream input and operand read port shared by the loader and its users.
// master drives bytes and read addresses; slave is the loader itself.
interface memoria_cargador_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [BYTE_WIDTH-1:0] byte_i;
  logic                  byte_valid_i;
  logic                  byte_ready_o;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] operador_o;

  modport master (
    output byte_i, byte_valid_i, addr_i,
    input  byte_ready_o, operador_o
  );

  modport slave (
    input  byte_i, byte_valid_i, addr_i,
    output byte_ready_o, operador_o
  );
endinterface

// File: rtl/memoria_cargador.sv
// Byte-serial loader: packs LSB-first bytes into words and writes them into an
// 8-entry operand memory at an auto-incrementing pointer; combinational read port.
//
// state       | meaning
// ST_ASSEMBLE | accepting bytes into the assembly register
// ST_WRITE    | one-cycle commit of the assembled word to memory[wr_ptr]
// ST_FULL     | all words loaded; bytes refused until clear or reset
module memoria_cargador #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clear_i,
  memoria_cargador_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o,
  output logic                  full_o,
  output logic                  done_o
);

  localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    ST_ASSEMBLE,
    ST_WRITE,
    ST_FULL
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  full_q, full_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  ready;

  // Ready is a pure function of state, so no path exists from byte_valid_i.
  assign ready            = (state_q == ST_ASSEMBLE);
  assign bus.byte_ready_o = ready;
  assign bus.operador_o   = mem_q[bus.addr_i];
  assign wr_ptr_o         = ptr_q;
  assign full_o           = full_q;
  assign done_o           = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    ptr_d   = ptr_q;
    full_d  = full_q;
    done_d  = 1'b0;
    mem_d   = mem_q;

    case (state_q)
      ST_ASSEMBLE: begin
        if (bus.byte_valid_i) begin
          for (int k = 0; k < BYTES; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              asm_d[k*BYTE_WIDTH +: BYTE_WIDTH] = bus.byte_i;
            end
          end
          if (cnt_q == CNT_W'(BYTES - 1)) begin
            state_d = ST_WRITE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WRITE: begin
        mem_d[ptr_q] = asm_q;
        cnt_d        = '0;
        if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
          ptr_d   = '0;
          full_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_FULL;
        end else begin
          ptr_d   = ptr_q + ADDR_WIDTH'(1);
          state_d = ST_ASSEMBLE;
        end
      end
      ST_FULL: begin
        state_d = ST_FULL;
      end
      default: begin
        state_d = ST_ASSEMBLE;
      end
    endcase

    // Clear restarts loading and cancels any byte or commit on the same edge.
    if (clear_i) begin
      state_d = ST_ASSEMBLE;
      cnt_d   = '0;
      asm_d   = '0;
      ptr_d   = '0;
      full_d  = 1'b0;
      done_d  = 1'b0;
      mem_d   = mem_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_ASSEMBLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      ptr_q   <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      ptr_q   <= ptr_d;
      full_q  <= full_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_memoria_cargador.sv
// Scoreboard bench for memoria_cargador: expected words are queued as they are
// sent and popped against the read port once the commit is observed.
module tb_memoria_cargador;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int AW = 3;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] w;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          done;

  exp_t          sb_q[$];
  logic [DW-1:0] exp_mem [8];
  logic [AW-1:0] model_ptr;
  int            n_vec = 0;
  int            n_err = 0;

  memoria_cargador_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  memoria_cargador #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .clear_i (clear),
    .bus     (bus),
    .wr_ptr_o(wr_ptr),
    .full_o  (full),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [BW-1:0] b, input int gap);
    logic rdy;
    int   tries;
    repeat (gap) begin
      @(negedge clk);
      bus.byte_valid_i = 1'b0;
      @(posedge clk);
    end
    tries = 0;
    forever begin
      @(negedge clk);
      bus.byte_i       = b;
      bus.byte_valid_i = 1'b1;
      rdy              = bus.byte_ready_o;
      @(posedge clk);
      if (rdy) break;
      tries++;
      if (tries > 20) begin
        check_eq("accept_timeout", 32'(rdy), 32'd1);
        break;
      end
    end
  endtask

  // Leaves the bench at the negedge inside the WRITE cycle.
  task automatic send_word(input logic [DW-1:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[k*BW +: BW], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
    sb_q.push_back('{a: model_ptr, w: w});
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
    check_eq("ready_in_write", 32'(bus.byte_ready_o), 32'd0);
  endtask

  task automatic wait_commit();
    logic seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.byte_ready_o || full) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq("commit_timeout", 32'(seen), 32'd1);
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      exp_mem[e.a] = e.w;
      model_ptr    = e.a + AW'(1);
      bus.addr_i   = e.a;
      #1;
      check_eq($sformatf("word@%0d", e.a), bus.operador_o, e.w);
      check_eq("wr_ptr", 32'(wr_ptr), 32'(model_ptr));
    end
  endtask

  task automatic dump_check(input string tag);
    for (int a = 0; a < 8; a++) begin
      bus.addr_i = AW'(a);
      #1;
      check_eq($sformatf("%s[%0d]", tag, a), bus.operador_o, exp_mem[a]);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear     = 1'b0;
    model_ptr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.byte_i       = '0;
    bus.byte_valid_i = 1'b0;
    bus.addr_i       = '0;
    model_ptr        = '0;
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_ready", 32'(bus.byte_ready_o), 32'd1);
    check_eq("rst_ptr", 32'(wr_ptr), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    dump_check("rst_mem");

    send_word(32'h350F6992, 0);
    wait_commit();

    do_clear();
    for (int i = 0; i < 8; i++) begin
      send_word(DW'(i + 1), 3);
      wait_commit();
      if (i < 7) check_eq("done_early", 32'(done), 32'd0);
    end
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("full_set", 32'(full), 32'd1);
    check_eq("full_ready", 32'(bus.byte_ready_o), 32'd0);
    check_eq("full_ptr", 32'(wr_ptr), 32'd0);
    @(negedge clk);
    check_eq("done_width", 32'(done), 32'd0);
    repeat (6) begin
      bus.byte_valid_i = 1'b1;
      bus.byte_i       = BW'($urandom);
      @(negedge clk);
    end
    bus.byte_valid_i = 1'b0;
    check_eq("full_hold", 32'(full), 32'd1);
    check_eq("full_ptr_hold", 32'(wr_ptr), 32'd0);
    dump_check("full_ignore");

    do_clear();
    for (int i = 0; i < 3; i++) begin
      send_word(32'hC0DE0000 + DW'(i), 2);
      wait_commit();
    end
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(negedge clk);
    clear            = 1'b1;
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = 8'hCC;
    @(posedge clk);
    @(negedge clk);
    clear            = 1'b0;
    bus.byte_valid_i = 1'b0;
    model_ptr        = '0;
    check_eq("clr_ptr", 32'(wr_ptr), 32'd0);
    check_eq("clr_ready", 32'(bus.byte_ready_o), 32'd1);
    bus.addr_i = 3'd3;
    #1;
    check_eq("clr_mem3", bus.operador_o, exp_mem[3]);
    send_word(32'h44332211, 0);
    wait_commit();

    do_clear();
    for (int k = 0; k < 4; k++) send_byte(BW'(k + 1), 0);
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
    check_eq("clrw_in_write", 32'(bus.byte_ready_o), 32'd0);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    check_eq("clrw_ptr", 32'(wr_ptr), 32'd0);
    check_eq("clrw_ready", 32'(bus.byte_ready_o), 32'd1);
    check_eq("clrw_full", 32'(full), 32'd0);
    bus.addr_i = 3'd0;
    #1;
    check_eq("clrw_mem0", bus.operador_o, exp_mem[0]);

    do_clear();
    for (int i = 0; i < 8; i++) begin
      send_word($urandom | 32'h1, 1);
      wait_commit();
    end
    check_eq("pre_rst_full", 32'(full), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    model_ptr = '0;
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;
    check_eq("rst2_full", 32'(full), 32'd0);
    check_eq("rst2_ready", 32'(bus.byte_ready_o), 32'd1);
    check_eq("rst2_ptr", 32'(wr_ptr), 32'd0);
    check_eq("rst2_done", 32'(done), 32'd0);
    dump_check("rst2_mem");
    send_word(32'hDEADBEEF, 1);
    wait_commit();
    dump_check("final_mem");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/memoria_cargador.md
Name: memoria_cargador

Overview:
- Write-side companion to the ALU operand memories: a byte-serial loader that assembles incoming bytes into 32-bit words.
- Writes each word into an 8-entry operand memory at an auto-incrementing address.
- Exposes the same combinational read port (addr_i -> operador_o) that the ALU datapath consumes, so operands are loaded at run time instead of by initial blocks.

Parameters:
- DATA_WIDTH, 32, word width stored and read; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, width of each input beat.
- ADDR_WIDTH, 3, address width; depth = 2**ADDR_WIDTH = 8 words.

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_n_i  input  1  synchronous, active-low reset.
- clear_i  input  1  synchronous restart of loading (pointer/assembly only; memory kept).
- byte_i  input  BYTE_WIDTH  incoming data byte, LSB byte of a word first.
- byte_valid_i  input  1  byte_i valid this cycle.
- byte_ready_o  output  1  loader can accept a byte this cycle.
- addr_i  input  ADDR_WIDTH  read address.
- operador_o  output  DATA_WIDTH  memory[addr_i], combinational.
- wr_ptr_o  output  ADDR_WIDTH  address the next completed word will be written to.
- full_o  output  1  all 8 words loaded since last reset/clear.
- done_o  output  1  one-cycle pulse when the 8th word is committed.

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - all memory words are set to 0
  - state=ASSEMBLE, byte count=0, assembly register=0, wr_ptr_o=0
  - full_o=0, done_o=0, byte_ready_o=1 from the first cycle after reset
  - reset overrides clear_i and any in-flight transfer
- Handshake: a byte transfers on a rising edge where byte_valid_i=1 and byte_ready_o=1. byte_i is ignored otherwise. byte_ready_o depends only on state and has no combinational path from byte_valid_i.
- States:
  - ASSEMBLE: byte_ready_o=1. On each transfer, byte k (k=0..BYTES-1) is stored into bits [k*BYTE_WIDTH +: BYTE_WIDTH] and the count increments. On transfer of byte BYTES-1, go to WRITE.
  - WRITE: byte_ready_o=0, lasting exactly one cycle. At the end of the cycle, memory[wr_ptr] <= assembled word and the count returns to 0.
    - If wr_ptr==7: wr_ptr wraps to 0, full_o<=1, done_o pulses high for the next cycle, go to FULL.
    - Otherwise: wr_ptr<=wr_ptr+1, go to ASSEMBLE.
  - FULL: byte_ready_o=0 and bytes are ignored; stays here until clear_i or reset.
- Throughput: 1 word per BYTES+1 cycles (5 at defaults) with continuous valid.
- Latency: the edge that accepts the last byte enters WRITE, and the next edge commits. The new word is visible on operador_o in the cycle after WRITE.
- Read port:
  - Purely combinational, no enable.
  - A read of the address being committed returns the old value during the WRITE cycle and the new value afterwards.
  - addr_i is independent of the load state; reading while loading is legal.
- clear_i (with rst_n_i=1), in any state:
  - Next state=ASSEMBLE, count=0, assembly register=0, wr_ptr=0, full_o=0, done_o=0.
  - Memory contents are preserved.
  - clear_i beats a simultaneous byte transfer (that byte is dropped) and a simultaneous WRITE commit (the word is not written).
- A partial word (fewer than BYTES bytes) is never written. It is discarded only by clear_i or reset.
- Width rules: wr_ptr increments modulo 2**ADDR_WIDTH. There is no sign extension and no byte reordering beyond LSB-first placement.

Test Plan:
- Reset then idle: rst_n_i=0 for 2 cycles, then release -> operador_o=0 for addr_i=0..7, byte_ready_o=1, wr_ptr_o=0, full_o=0, done_o=0.
- Single word: send 0x92,0x69,0x0F,0x35 on consecutive cycles with addr_i=0 -> byte_ready_o=0 for 1 cycle, then operador_o=32'h350F6992, wr_ptr_o=1.
- Backpressure/gaps:
  - Stimulus: drive byte_valid_i with random idle cycles while sending 8 words 0x00000001..0x00000008.
  - Required: memory[i]=i+1 for i=0..7.
  - Required: done_o high for exactly 1 cycle after the 8th commit; full_o=1, byte_ready_o=0, wr_ptr_o=0.
  - Required: extra valid bytes are ignored.
- Clear mid-word: after 2 bytes 0xAA,0xBB of word 3, assert clear_i with byte_valid_i=1 -> wr_ptr_o=0, memory[3] unchanged. The next 4 bytes 0x11,0x22,0x33,0x44 land at memory[0]=32'h44332211.
- Clear during WRITE cycle: assert clear_i exactly in the WRITE cycle of word 0 (bytes 0x01..0x04) -> memory[0] keeps its prior value, wr_ptr_o=0.
- Reset mid-operation: from FULL with non-zero memory, pulse rst_n_i=0 for 1 cycle -> all operador_o reads 0, full_o=0, byte_ready_o=1. A new 4-byte load writes memory[0].
